fifo_stream_reader: RTL



---
 rtl/fifo_stream_reader.sv | 90 +++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for sync_fifo: drains the registered-read FIFO port into a
// 3-entry skid buffer and presents it as a valid/ready stream with packet framing.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [31:0]           beat_count
);

    localparam int              IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] mem [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            occupancy;
    logic                  inflight;
    logic [IDX_W-1:0]      beat_idx;
    logic [2:0]            committed;
    logic                  push;
    logic                  pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // An in-flight read already owns a slot, so it counts against free space;
    // this keeps m_ready out of the read-issue path entirely.
    assign committed  = {1'b0, occupancy} + {2'b00, inflight};
    assign fifo_rd_en = rst_n & enable & ~fifo_empty & (committed < 3'd3);

    assign push    = inflight;
    assign pop     = m_valid & m_ready;
    assign m_valid = (occupancy != 2'd0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign m_last  = m_valid & (beat_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= fifo_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            occupancy <= 2'd0;
            inflight  <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx   <= '0;
            beat_count <= 32'd0;
        end else if (pop) begin
            beat_idx   <= (beat_idx == LAST_IDX) ? '0 : beat_idx + IDX_W'(1);
            beat_count <= beat_count + 32'd1;
        end
    end

endmodule
